regfile_scoreboard: RTL



---
 rtl/regfile_scoreboard.sv | 102 ++++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: decode-stage register file with a pending-write RAW scoreboard.
// Define REGFILE_BYPASS_EN for write-through reads and same-cycle hazard release.
module regfile_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int AW       = 4,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 15,
    parameter int CNT_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_dst,
    input  logic [NRD*AW-1:0]     issue_src,
    output logic                  stall,
    output logic                  issue_ack,
    output logic                  err_underflow,
    input  logic [AW-1:0]         dbg_addr,
    output logic [DATA_W-1:0]     dbg_data
);
    localparam int NREGS = 2**AW;
    localparam logic [AW-1:0] ZR = AW'(ZERO_REG);
    localparam logic [CNT_W-1:0] CMAX = '1;
    localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt  [NREGS];
    logic [DATA_W-1:0] dbg_q;
    logic              err_q;
    logic [NRD-1:0]    busy;
    logic [NREGS-1:0]  inc_v;
    logic [NREGS-1:0]  dec_v;
    logic              sat;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        logic [AW-1:0] a;
        logic [AW-1:0] s;
        logic          byp;
        logic          rel;
        assign a = rd_addr[k*AW +: AW];
        assign s = issue_src[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign byp = wb_en && wb_addr == a;
        assign rel = cnt[s] == CONE && wb_en && wb_addr == s;
`else
        assign byp = 1'b0;
        assign rel = 1'b0;
`endif
        assign rd_data[k*DATA_W +: DATA_W] =
            (a == ZR) ? '0 : (byp ? wb_data : regs[a]);
        assign busy[k] = s != ZR && cnt[s] != '0 && !rel;
    end

    // A full counter only blocks issue when no write-back frees a slot now
    assign sat = issue_dst != ZR && cnt[issue_dst] == CMAX &&
                 !(wb_en && wb_addr == issue_dst);
    assign stall = issue_valid && (|busy || sat);
    assign issue_ack = issue_valid && !stall;

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int r = 0; r < NREGS; r++) begin
            inc_v[r] = issue_ack && issue_dst == AW'(r) && AW'(r) != ZR;
            dec_v[r] = wb_en && wb_addr == AW'(r) && AW'(r) != ZR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            err_q <= 1'b0;
            dbg_q <= '0;
        end else begin
            dbg_q <= (dbg_addr == ZR) ? '0 : regs[dbg_addr];
            if (wb_en && wb_addr != ZR)
                regs[wb_addr] <= wb_data;
            for (int r = 0; r < NREGS; r++) begin
                if (inc_v[r] && !dec_v[r]) begin
                    cnt[r] <= cnt[r] + CONE;
                end else if (dec_v[r] && !inc_v[r]) begin
                    if (cnt[r] != '0)
                        cnt[r] <= cnt[r] - CONE;
                    else
                        err_q <= 1'b1;
                end
            end
        end
    end

    assign err_underflow = err_q;
    assign dbg_data = dbg_q;

endmodule
